jt6295_cmd: RTL and testbench

//  Host-side command transmitter for the jt6295 ADPCM core. Accepts one play/stop request per

---
 rtl/jt6295_pkg.sv | 37 +++
 rtl/jt6295_cmd.sv | 173 +++++++++++++++++
 tb/tb_jt6295_cmd.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/jt6295_pkg.sv
// Shared definitions for the jt6295 host command transmitter: FSM states and
// CPU-bus byte builders for play/stop commands.
package jt6295_pkg;

  localparam int unsigned CMD_PLAY_BIT  = 7;
  localparam int unsigned STOP_MASK_LSB = 3;

  typedef enum logic [2:0] {
    StIdle,
    StWaitB,
    StSetup,
    StLow,
    StHigh,
    StGap,
    StConf,
    StDone
  } cmd_state_e;

  function automatic logic [7:0] play_byte0(input logic [6:0] phrase);
    logic [7:0] b;
    b = {1'b0, phrase};
    b[CMD_PLAY_BIT] = 1'b1;
    return b;
  endfunction

  function automatic logic [7:0] play_byte1(input logic [3:0] ch, input logic [3:0] att);
    return {ch, att};
  endfunction

  function automatic logic [7:0] stop_byte(input logic [3:0] ch);
    logic [7:0] b;
    b = '0;
    b[STOP_MASK_LSB +: 4] = ch;
    return b;
  endfunction

endpackage

// File: rtl/jt6295_cmd.sv
// Serialises one play/stop request at a time onto the jt6295 CPU write bus
// (wrn/dout), optionally waiting for idle voices and confirming playback.
module jt6295_cmd
  import jt6295_pkg::*;
#(
  parameter int unsigned WR_LOW    = 2,
  parameter int unsigned WR_HOLD   = 2,
  parameter int unsigned GAP       = 16,
  parameter int unsigned TMO       = 64,
  parameter int unsigned WAIT_BUSY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_play,
  input  logic [6:0] req_phrase,
  input  logic [3:0] req_ch,
  input  logic [3:0] req_att,
  output logic       wrn,
  output logic [7:0] dout,
  input  logic [3:0] busy,
  output logic       done,
  output logic       err
);

  if (WR_LOW < 1 || WR_LOW > 255 || WR_HOLD < 1 || WR_HOLD > 255 ||
      GAP < 1 || GAP > 255 || TMO < 1 || TMO > 255) begin : g_bad_param
    $error("jt6295_cmd: tick parameters must be in 1..255");
  end

  localparam logic [7:0] LowLd  = 8'(WR_LOW - 1);
  localparam logic [7:0] HoldLd = 8'(WR_HOLD - 1);
  localparam logic [7:0] GapLd  = 8'(GAP - 1);
  localparam logic [7:0] TmoLd  = 8'(TMO - 1);

  cmd_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       sel1_q, sel1_d;
  logic       play_q, play_d;
  logic [6:0] phrase_q, phrase_d;
  logic [3:0] ch_q, ch_d;
  logic [3:0] att_q, att_d;
  logic       err_set;
  logic [7:0] byte_d;
  logic       wrn_q, req_ready_q, done_q, err_q;
  logic [7:0] dout_q;
  logic       accept;

  assign accept = req_valid & req_ready_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel1_d   = sel1_q;
    err_set  = 1'b0;
    play_d   = play_q;
    phrase_d = phrase_q;
    ch_d     = ch_q;
    att_d    = att_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          play_d   = req_play;
          phrase_d = req_phrase;
          ch_d     = req_ch;
          att_d    = req_att;
          sel1_d   = 1'b0;
          state_d  = (req_play && WAIT_BUSY != 0) ? StWaitB : StSetup;
        end
      end
      StWaitB: if ((busy & ch_q) == 4'd0) state_d = StSetup;
      StSetup: begin
        state_d = StLow;
        cnt_d   = LowLd;
      end
      StLow: begin
        if (cen) begin
          if (cnt_q == 8'd0) begin
            state_d = StHigh;
            cnt_d   = HoldLd;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      StHigh: begin
        if (cen) begin
          if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
          end else if (play_q && !sel1_q) begin
            sel1_d  = 1'b1;
            state_d = StSetup;
          end else if (play_q) begin
            state_d = StGap;
            cnt_d   = GapLd;
          end else begin
            state_d = StDone;
          end
        end
      end
      StGap: begin
        if (cen) begin
          if (cnt_q == 8'd0) begin
            state_d = StConf;
            cnt_d   = TmoLd;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      StConf: begin
        // Partial busy patterns keep waiting; only the full mask confirms.
        if (ch_q == 4'd0 || (busy & ch_q) == ch_q) begin
          state_d = StDone;
        end else if (cen) begin
          if (cnt_q == 8'd0) begin
            state_d = StDone;
            err_set = 1'b1;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Byte for the next SETUP, built from the values being captured this edge.
  always_comb begin
    if (play_d) byte_d = sel1_d ? play_byte1(ch_d, att_d) : play_byte0(phrase_d);
    else        byte_d = stop_byte(ch_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sel1_q      <= 1'b0;
      play_q      <= 1'b0;
      phrase_q    <= '0;
      ch_q        <= '0;
      att_q       <= '0;
      wrn_q       <= 1'b1;
      dout_q      <= '0;
      req_ready_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel1_q      <= sel1_d;
      play_q      <= play_d;
      phrase_q    <= phrase_d;
      ch_q        <= ch_d;
      att_q       <= att_d;
      wrn_q       <= (state_d != StLow);
      req_ready_q <= (state_d == StIdle);
      done_q      <= (state_d == StDone);
      err_q       <= err_set;
      if (state_d == StSetup) dout_q <= byte_d;
    end
  end

  assign wrn       = wrn_q;
  assign dout      = dout_q;
  assign req_ready = req_ready_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_jt6295_cmd.sv
// Self-checking bench for jt6295_cmd: bus monitor with scoreboard queues and a
// behavioural voice-busy model standing in for the core.
module tb_jt6295_cmd;

  localparam int unsigned WR_LOW  = 2;
  localparam int unsigned WR_HOLD = 2;
  localparam int unsigned GAP     = 16;
  localparam int unsigned TMO     = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_play = 1'b0;
  logic [6:0] req_phrase = '0;
  logic [3:0] req_ch = '0;
  logic [3:0] req_att = '0;
  logic       wrn;
  logic [7:0] dout;
  logic [3:0] busy = '0;
  logic       done;
  logic       err;

  jt6295_cmd #(
    .WR_LOW   (WR_LOW),
    .WR_HOLD  (WR_HOLD),
    .GAP      (GAP),
    .TMO      (TMO),
    .WAIT_BUSY(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cen       (cen),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_play  (req_play),
    .req_phrase(req_phrase),
    .req_ch    (req_ch),
    .req_att   (req_att),
    .wrn       (wrn),
    .dout      (dout),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_bytes[$];
  bit         exp_err[$];
  logic [3:0] model_busy = '0;
  logic [3:0] busy_hold = '0;
  bit         auto_en = 1'b1;
  bit         expect_byte1 = 1'b0;
  int         done_cnt = 0;
  int         byte_cnt = 0;
  int         acc_cnt = 0;
  int         ticks = 0;
  int         last_ticks = 0;
  int         ready_low_viol = 0;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor, busy model and cen generator in one process so sampling order is fixed.
  initial begin
    int   div;
    bit   cen_used;
    logic wrn_prev;
    div = 0;
    wrn_prev = 1'b1;
    forever begin
      @(negedge clk);
      cen_used = cen;
      if (!rst_n) begin
        exp_bytes.delete();
        exp_err.delete();
        wrn_prev = 1'b1;
        expect_byte1 = 1'b0;
      end else begin
        if (cen_used) ticks++;
        if (req_ready && !wrn) ready_low_viol++;
        if (!wrn_prev && wrn) begin
          byte_cnt++;
          ticks = 0;
          if (exp_bytes.size() == 0) check("extra_byte", int'(dout), -1);
          else check("wr_byte", int'(dout), int'(exp_bytes.pop_front()));
          if (expect_byte1) begin
            expect_byte1 = 1'b0;
            if (auto_en) model_busy = model_busy | dout[7:4];
          end else if (dout[7]) begin
            expect_byte1 = 1'b1;
          end else begin
            model_busy = model_busy & ~dout[6:3];
          end
        end
        if (done) begin
          done_cnt++;
          last_ticks = ticks;
          if (exp_err.size() == 0) check("extra_done", 1, 0);
          else check("done_err", int'(err), int'(exp_err.pop_front()));
        end
        wrn_prev = wrn;
      end
      busy = model_busy | busy_hold;
      cen = (div % 4 == 3);
      div++;
    end
  end

  task automatic send(input bit play, input logic [6:0] ph, input logic [3:0] ch,
                      input logic [3:0] att, input logic [7:0] b0, input logic [7:0] b1,
                      input bit e);
    int n;
    n = 0;
    req_valid  = 1'b1;
    req_play   = play;
    req_phrase = ph;
    req_ch     = ch;
    req_att    = att;
    exp_bytes.push_back(b0);
    if (play) exp_bytes.push_back(b1);
    exp_err.push_back(e);
    while (!req_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", int'(req_ready), 1);
    @(posedge clk);
    #1;
    acc_cnt++;
    // Scramble the request fields; the DUT must keep what it captured.
    req_play   = ~play;
    req_phrase = ~ph;
    req_ch     = ~ch;
    req_att    = ~att;
    @(negedge clk);
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("done_count", done_cnt, target);
  endtask

  typedef struct {
    bit         play;
    logic [6:0] phrase;
    logic [3:0] ch;
    logic [3:0] att;
    logic [7:0] b0;
    logic [7:0] b1;
    bit         e;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int abase;
    int lowcnt;
    int bsnap;
    int n;

    vecs[0] = '{1'b1, 7'h05, 4'b0010, 4'h3, 8'h85, 8'h23, 1'b0};
    vecs[1] = '{1'b1, 7'h7F, 4'b1001, 4'hF, 8'hFF, 8'h9F, 1'b0};
    vecs[2] = '{1'b0, 7'h00, 4'b1001, 4'h0, 8'h48, 8'h00, 1'b0};
    vecs[3] = '{1'b1, 7'h00, 4'b0000, 4'h0, 8'h80, 8'h00, 1'b0};
    vecs[4] = '{1'b0, 7'h12, 4'b0000, 4'h7, 8'h00, 8'h00, 1'b0};
    vecs[5] = '{1'b0, 7'h00, 4'b1111, 4'h0, 8'h78, 8'h00, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_wrn", int'(wrn), 1);
    check("rst_dout", int'(dout), 0);
    check("rst_ready", int'(req_ready), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", int'(req_ready), 1);

    foreach (vecs[i]) begin
      base = done_cnt;
      send(vecs[i].play, vecs[i].phrase, vecs[i].ch, vecs[i].att, vecs[i].b0, vecs[i].b1,
           vecs[i].e);
      req_valid = 1'b0;
      wait_done(base + 1);
    end
    repeat (4) @(negedge clk);
    check("busy_after_stop_all", int'(busy), 0);

    // Play must stall while its voice is busy.
    busy_hold = 4'b0100;
    base = done_cnt;
    send(1'b1, 7'h11, 4'b0100, 4'h6, 8'h91, 8'h46, 1'b0);
    req_valid = 1'b0;
    lowcnt = 0;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (!wrn) lowcnt++;
    end
    check("waitb_wrn_low", lowcnt, 0);
    check("waitb_no_done", done_cnt, base);
    busy_hold = 4'b0000;
    wait_done(base + 1);

    // Unconfirmed play times out exactly TMO ticks after the gap.
    auto_en = 1'b0;
    base = done_cnt;
    send(1'b1, 7'h22, 4'b0001, 4'h1, 8'hA2, 8'h11, 1'b1);
    req_valid = 1'b0;
    wait_done(base + 1);
    check("tmo_ticks", last_ticks, int'(WR_HOLD + GAP + TMO));
    auto_en = 1'b1;

    // Reset during the first byte's low phase.
    base = done_cnt;
    send(1'b1, 7'h33, 4'b1000, 4'h2, 8'hB3, 8'h82, 1'b0);
    req_valid = 1'b0;
    n = 0;
    while (wrn && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reached_low", int'(wrn), 0);
    rst_n = 1'b0;
    #1;
    check("midrst_wrn", int'(wrn), 1);
    check("midrst_dout", int'(dout), 0);
    check("midrst_ready", int'(req_ready), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bsnap = byte_cnt;
    @(negedge clk);
    check("ready_after_midrst", int'(req_ready), 1);
    repeat (200) @(negedge clk);
    check("no_partial_byte", byte_cnt, bsnap);
    check("no_done_after_rst", done_cnt, base);
    check("model_cmd_idle", int'(expect_byte1), 0);

    // Back-to-back requests with valid held high.
    base  = done_cnt;
    abase = acc_cnt;
    send(1'b1, 7'h01, 4'b0001, 4'h0, 8'h81, 8'h10, 1'b0);
    send(1'b1, 7'h40, 4'b0010, 4'h5, 8'hC0, 8'h25, 1'b0);
    send(1'b0, 7'h00, 4'b0111, 4'h0, 8'h38, 8'h00, 1'b0);
    req_valid = 1'b0;
    wait_done(base + 3);
    check("accepts_vs_dones", done_cnt - base, acc_cnt - abase);
    repeat (10) @(negedge clk);
    check("ready_low_when_busy", ready_low_viol, 0);
    check("exp_bytes_left", exp_bytes.size(), 0);
    check("exp_err_left", exp_err.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
